// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR random source: FSM states, limiter modes
// and a table of primitive Galois feedback masks (bit i = coefficient of x^i, x^WIDTH implied).
package lfsr_pkg;

    typedef enum logic {
        DRAW = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int MODE_CLAMP  = 0;
    localparam int MODE_REJECT = 1;

    function automatic logic [31:0] default_taps(input int width);
        logic [31:0] taps;
        case (width)
            4:       taps = 32'h0000_0009;
            5:       taps = 32'h0000_0009;
            6:       taps = 32'h0000_0021;
            7:       taps = 32'h0000_0041;
            8:       taps = 32'h0000_0071;
            9:       taps = 32'h0000_0021;
            10:      taps = 32'h0000_0081;
            11:      taps = 32'h0000_0201;
            12:      taps = 32'h0000_0053;
            13:      taps = 32'h0000_001B;
            14:      taps = 32'h0000_002B;
            15:      taps = 32'h0000_4001;
            16:      taps = 32'h0000_A011;
            17:      taps = 32'h0000_4001;
            18:      taps = 32'h0000_0801;
            19:      taps = 32'h0000_0047;
            20:      taps = 32'h0002_0001;
            21:      taps = 32'h0008_0001;
            22:      taps = 32'h0020_0001;
            23:      taps = 32'h0004_0001;
            24:      taps = 32'h00C2_0001;
            25:      taps = 32'h0040_0001;
            26:      taps = 32'h0000_0047;
            27:      taps = 32'h0000_0027;
            28:      taps = 32'h0200_0001;
            29:      taps = 32'h0800_0001;
            30:      taps = 32'h0000_0053;
            31:      taps = 32'h1000_0001;
            32:      taps = 32'h0040_0007;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an active-low push-button plus a one-cycle falling-edge pulse.
// Flops reset to the released level so a button held through reset yields one edge afterwards.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign fall = prev & ~sync2;

endmodule

// File: rtl/lfsr_rng.sv
// Galois LFSR random source with clamp/reject range limiting and a valid/ready output.
// Optional build macro LFSR_LOCKUP_GUARD_EN adds recovery from the all-zero LFSR state.
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] TAPS      = 32'h71,
    parameter logic [31:0] SEED_INIT = 32'h7F,
    parameter logic [31:0] MAX_OUT   = 32'd240,
    parameter int          MODE      = MODE_REJECT,
    parameter int          REJ_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_btn,
    input  logic             seed_load,
    input  logic             rand_ready,
    output logic             rand_valid,
    output logic [WIDTH-1:0] rand_out,
    output logic [WIDTH-1:0] seed_q
);

    localparam int               CW         = (REJ_LIMIT > 1) ? $clog2(REJ_LIMIT) : 1;
    localparam logic [WIDTH-1:0] TAP_MASK   = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_RST   = SEED_INIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] OUT_MAX    = MAX_OUT[WIDTH-1:0];
    localparam logic [CW-1:0]    REJ_LAST   = CW'(REJ_LIMIT - 1);
    localparam bit               CLAMP_ONLY = (MODE == MODE_CLAMP);

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] lfsr_step;
    logic [CW-1:0]    rej_cnt;
    logic             btn_fall;
    logic             cand_ok;
    logic             accept;

    btn_sync_edge u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (seed_btn),
        .fall  (btn_fall)
    );

    assign nxt = {lfsr[WIDTH-2:0], 1'b0} ^ (lfsr[WIDTH-1] ? TAP_MASK : '0);

`ifdef LFSR_LOCKUP_GUARD_EN
    logic lfsr_zero;
    assign lfsr_zero = (lfsr == '0);
    assign lfsr_step = lfsr_zero ? WIDTH'(1) : nxt;
    assign cand_ok   = !lfsr_zero;
`else
    assign lfsr_step = nxt;
    assign cand_ok   = 1'b1;
`endif

    assign accept = cand_ok && (CLAMP_ONLY || (nxt <= OUT_MAX) || (rej_cnt == REJ_LAST));

    // Seed never reaches zero: stepping down from 1 wraps to all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q <= SEED_RST;
        end else if (btn_fall) begin
            seed_q <= (seed_q == WIDTH'(1)) ? '1 : seed_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= SEED_RST;
            state      <= DRAW;
            rand_out   <= '0;
            rand_valid <= 1'b0;
            rej_cnt    <= '0;
        end else if (seed_load) begin
            lfsr       <= seed_q;
            state      <= DRAW;
            rand_valid <= 1'b0;
            rej_cnt    <= '0;
        end else begin
            lfsr <= lfsr_step;
            case (state)
                DRAW: begin
                    if (accept) begin
                        rand_out   <= (nxt > OUT_MAX) ? OUT_MAX : nxt;
                        rand_valid <= 1'b1;
                        rej_cnt    <= '0;
                        state      <= HOLD;
                    end else if (rej_cnt != REJ_LAST) begin
                        rej_cnt <= rej_cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (rand_ready) begin
                        rand_valid <= 1'b0;
                        state      <= DRAW;
                    end
                end
                default: state <= DRAW;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: GF(2^8) reference model on the default build under random traffic,
// plus directed literal checks on clamp, full-range and forced-clamp configurations.
module tb_lfsr_rng;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       d_btn = 1'b1, d_load = 1'b0, d_ready = 1'b0;
    logic       d_valid;
    logic [7:0] d_out, d_seed;
    logic       c_valid;
    logic [7:0] c_out, c_seed;
    logic       f_valid;
    logic [7:0] f_out, f_seed;
    logic       z_load = 1'b0;
    logic       z_valid;
    logic [7:0] z_out, z_seed;

    int checks = 0;
    int errors = 0;

    lfsr_rng u_dut (
        .clk(clk), .rst_n(rst_n), .seed_btn(d_btn), .seed_load(d_load), .rand_ready(d_ready),
        .rand_valid(d_valid), .rand_out(d_out), .seed_q(d_seed)
    );

    lfsr_rng #(.MODE(0)) u_clp (
        .clk(clk), .rst_n(rst_n), .seed_btn(1'b1), .seed_load(1'b0), .rand_ready(1'b0),
        .rand_valid(c_valid), .rand_out(c_out), .seed_q(c_seed)
    );

    lfsr_rng #(.MODE(0), .MAX_OUT(32'd255)) u_full (
        .clk(clk), .rst_n(rst_n), .seed_btn(1'b1), .seed_load(1'b0), .rand_ready(1'b1),
        .rand_valid(f_valid), .rand_out(f_out), .seed_q(f_seed)
    );

    lfsr_rng #(.MAX_OUT(32'd0), .REJ_LIMIT(3)) u_zero (
        .clk(clk), .rst_n(rst_n), .seed_btn(1'b1), .seed_load(z_load), .rand_ready(1'b0),
        .rand_valid(z_valid), .rand_out(z_out), .seed_q(z_seed)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stepping a Galois LFSR is multiplication by x modulo x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] gf_double(input logic [7:0] v);
        int x;
        x = int'(v) * 2;
        if (x >= 256) x = x ^ 'h171;
        return x[7:0];
    endfunction

    logic [7:0] m_lfsr, m_seed, m_out, m_cand;
    logic       m_valid, m_dec;
    logic [2:0] raw_hist;
    int         m_rej;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_lfsr = 8'h7F; m_seed = 8'h7F; m_out = 8'h00; m_valid = 1'b0; m_rej = 0;
            raw_hist = 3'b111;
        end else begin
            // Button sampled 3 edges ago released and 2 edges ago pressed.
            m_dec = raw_hist[2] && !raw_hist[1];
            raw_hist = {raw_hist[1:0], d_btn};
            if (d_load) begin
                m_lfsr = m_seed; m_valid = 1'b0; m_rej = 0;
            end else begin
                m_cand = gf_double(m_lfsr);
                m_lfsr = m_cand;
                if (!m_valid) begin
                    if (m_cand <= 8'd240 || m_rej == 7) begin
                        m_out = (m_cand > 8'd240) ? 8'd240 : m_cand;
                        m_valid = 1'b1; m_rej = 0;
                    end else begin
                        m_rej++;
                    end
                end else if (d_ready) begin
                    m_valid = 1'b0;
                end
            end
            if (m_dec) m_seed = (m_seed == 8'h01) ? 8'hFF : m_seed - 8'h01;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("model_valid", 32'(d_valid), 32'(m_valid));
            chk("model_out",   32'(d_out),   32'(m_out));
            chk("model_seed",  32'(d_seed),  32'(m_seed));
        end
    end

    logic [7:0] full_vals[$];
    initial forever begin
        @(negedge clk);
        if (rst_n && f_valid && full_vals.size() < 256) full_vals.push_back(f_out);
    end

    task automatic press();
        for (int i = 0; i < 6; i++) begin
            d_btn   = (i >= 3);
            d_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            d_ready = ($urandom_range(0, 3) != 0);
            d_load  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 5) == 0) d_btn = ~d_btn;
            @(negedge clk);
        end
        d_load = 1'b0;
    endtask

    bit seen[256];
    int distinct, zeros;

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(d_valid), 0);
        chk("rst_out",   32'(d_out),   0);
        chk("rst_seed",  32'(d_seed),  32'h7F);
        chk("rst_zero_valid", 32'(z_valid), 0);
        rst_n = 1'b1;

        @(negedge clk);
        chk("first_reject",     32'(d_valid), 0);
        chk("model_pin_lfsr",   32'(m_lfsr),  32'hFE);
        chk("clamp_first_vld",  32'(c_valid), 1);
        chk("clamp_first_out",  32'(c_out),   32'hF0);
        chk("full_first_out",   32'(f_out),   32'hFE);
        @(negedge clk);
        chk("second_valid",     32'(d_valid), 1);
        chk("second_out",       32'(d_out),   32'h8D);
        chk("model_pin_out",    32'(m_out),   32'h8D);
        chk("zero_not_yet",     32'(z_valid), 0);
        @(negedge clk);
        chk("hold_valid",       32'(d_valid), 1);
        chk("hold_out",         32'(d_out),   32'h8D);
        chk("clamp_hold_out",   32'(c_out),   32'hF0);
        chk("zero_forced_vld",  32'(z_valid), 1);
        chk("zero_forced_out",  32'(z_out),   0);
        z_load = 1'b1;
        @(negedge clk);
        z_load = 1'b0;
        chk("zero_load_clears", 32'(z_valid), 0);

        d_btn = 1'b0;
        @(negedge clk); chk("btn_lat1", 32'(d_seed), 32'h7F);
        @(negedge clk); chk("btn_lat2", 32'(d_seed), 32'h7F);
        @(negedge clk); chk("btn_lat3", 32'(d_seed), 32'h7E);
        repeat (2) @(negedge clk);
        d_btn = 1'b1;
        repeat (4) @(negedge clk);
        chk("btn_single_dec", 32'(d_seed), 32'h7E);
        d_load = 1'b1;
        @(negedge clk);
        d_load = 1'b0;
        chk("load_clears", 32'(d_valid), 0);
        @(negedge clk); chk("load_reject_fc", 32'(d_valid), 0);
        @(negedge clk);
        chk("load_accept_vld", 32'(d_valid), 1);
        chk("load_accept_out", 32'(d_out),   32'h89);

        repeat (125) press();
        chk("seed_at_one", 32'(d_seed), 32'h01);
        press();
        chk("seed_wrap", 32'(d_seed), 32'hFF);

        d_ready = 1'b0;
        d_btn   = 1'b0;
        repeat (2) @(negedge clk);
        d_load = 1'b1;
        @(negedge clk);
        d_load = 1'b0;
        chk("coinc_seed", 32'(d_seed), 32'hFE);
        @(negedge clk);
        chk("coinc_valid", 32'(d_valid), 1);
        chk("coinc_old_seed", 32'(d_out), 32'h8F);
        d_btn = 1'b1;

        for (int i = 0; i < 2000 && full_vals.size() < 256; i++) @(negedge clk);
        chk("full_count", 32'(full_vals.size()), 256);
        if (full_vals.size() == 256) begin
            for (int i = 0; i < 256; i++) seen[i] = 1'b0;
            distinct = 0;
            zeros    = 0;
            for (int i = 0; i < 255; i++) begin
                if (full_vals[i] == 8'h00) zeros++;
                if (!seen[full_vals[i]]) begin
                    seen[full_vals[i]] = 1'b1;
                    distinct++;
                end
            end
            chk("full_distinct", 32'(distinct), 255);
            chk("full_nonzero",  32'(zeros),    0);
            chk("full_period",   32'(full_vals[255]), 32'(full_vals[0]));
        end

        rand_cycles(3000);

        d_ready = 1'b0;
        for (int i = 0; i < 40 && !d_valid; i++) @(negedge clk);
        chk("pre_reset_hold", 32'(d_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(d_valid), 0);
        chk("async_rst_out",   32'(d_out),   0);
        chk("async_rst_seed",  32'(d_seed),  32'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        rand_cycles(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
